serial_adder: RTL

- Multi-cycle, bit-serial adder computing {cout, c} = a + b + cin.
- Accepts operands on a valid/ready input handshake, computes one bit per clock with a single full-adder cell, and returns the sum on a valid/ready output handshake.
- Exists to be driven and checked by the lab3 counter-based stimulus/compare harness. The harness is the initiator; this block is the responder.
- Result must match the combinational ripple and look-ahead adders bit-for-bit.

---
 rtl/adder_pkg.sv | 13 +
 rtl/full_adder.sv | 14 +
 rtl/serial_adder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and defaults for the bit-serial adder family.
// Imported by the serial_adder top and by anything that needs its state encoding.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sadd_state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; purely combinational.
// The same cell is used by the ripple adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout, c} = a + b + cin, one bit per clock through a single
// full_adder cell, with valid/ready handshakes on both the operand and result sides.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  sadd_state_t      state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic fa_s;
  logic fa_co;
  logic last_bit;

  full_adder u_fa (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Handshake flags decode from state alone so they are never X after reset.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign c         = c_q;
  assign cout      = cout_q;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_d     = c_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Shift-based form keeps WIDTH=1 legal (no res[WIDTH-1:1] slice).
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = fa_s;
        sa_d             = sa_q >> 1;
        sb_d             = sb_q >> 1;
        carry_d          = fa_co;
        cnt_d            = cnt_q + CNT_W'(1);
        if (last_bit) begin
          c_d     = res_d;
          cout_d  = fa_co;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

endmodule
